// File: rtl/piso_bit_feeder_pkg.sv
// Shared types and helpers for the parallel-in/serial-out bit feeder.
package piso_bit_feeder_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bit-counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_feeder.sv
// Serialises WIDTH-bit words, one bit per clock, to feed the 1011 sequence detector.
// A one-word holding register lets consecutive words stream with no idle bit between them.
module piso_bit_feeder
    import piso_bit_feeder_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             sow,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_v;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic             sow_nxt;
    logic             last_bit;
    logic             load;
    logic             accept;
    logic             bypass;

    assign last_bit = (state == ST_SHIFT) && (bit_cnt == LAST_CNT);
    assign load     = hold_v && ((state == ST_IDLE) || last_bit);
    assign in_ready = ~rst & (~hold_v | load);
    assign accept   = in_valid & in_ready;
    // A word offered on the last-bit cycle with the hold empty goes straight
    // into the shifter, so the stream keeps running without a gap.
    assign bypass   = last_bit & ~hold_v & accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg <= '0;
            hold_v   <= 1'b0;
        end else if (accept && !bypass) begin
            hold_reg <= in_data;
            hold_v   <= 1'b1;
        end else if (load) begin
            hold_v   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            sow     <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            sow     <= sow_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        sow_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    state_nxt   = ST_SHIFT;
                    shreg_nxt   = hold_reg;
                    bit_cnt_nxt = '0;
                    sow_nxt     = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!last_bit) begin
                    if (MSB_FIRST) begin
                        shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
                    end else begin
                        shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
                    end
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end else if (load) begin
                    shreg_nxt   = hold_reg;
                    bit_cnt_nxt = '0;
                    sow_nxt     = 1'b1;
                end else if (bypass) begin
                    shreg_nxt   = in_data;
                    bit_cnt_nxt = '0;
                    sow_nxt     = 1'b1;
                end else begin
                    state_nxt   = ST_IDLE;
                    bit_cnt_nxt = '0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign dout_valid = (state == ST_SHIFT);
    assign dout       = dout_valid & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    assign busy       = hold_v | dout_valid;

endmodule

// File: tb/tb_piso_bit_feeder.sv
// Directed and scoreboarded checks of piso_bit_feeder, with a small 1011 detector model on dout.
module tb_piso_bit_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready, dout, dout_valid, sow, busy;

    logic [3:0] in_data4 = '0;
    logic       in_valid4 = 1'b0;
    logic       in_ready4, dout4, dout_valid4, sow4, busy4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid),
        .sow(sow), .busy(busy)
    );

    piso_bit_feeder #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
        .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .dout(dout4), .dout_valid(dout_valid4),
        .sow(sow4), .busy(busy4)
    );

    // Overlapping 1011 detector fed from dout; history clears between words.
    logic [2:0] hist;
    logic       y;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            y    <= 1'b0;
        end else if (dout_valid) begin
            hist <= {hist[1:0], dout};
            y    <= ({hist, dout} == 4'b1011);
        end else begin
            hist <= '0;
            y    <= 1'b0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 20)
                $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offers a word and waits for its transfer edge; in_valid stays high afterwards.
    task automatic apply_stimulus(input logic [7:0] w, output bit ok);
        bit acc;
        ok = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_output("accept_timeout", 32'(0), 32'(1));
    endtask

    typedef struct {
        logic [7:0] word;
        logic [7:0] bits;
        int         y_cnt;
        int         y_first;
    } vec_t;

    vec_t vecs[5];

    logic [7:0] exp_q[$];
    bit         mon_en = 1'b0;
    int         mon_idx = 0;
    logic [7:0] mon_word = '0;
    int         words_seen = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (dout_valid) begin
                if (sow) check_output("sb_align", 32'(mon_idx), 32'(0));
                mon_word = {mon_word[6:0], dout};
                mon_idx++;
                if (mon_idx == 8) begin
                    mon_idx = 0;
                    if (exp_q.size() == 0) begin
                        check_output("sb_extra_word", 32'(mon_word), 32'(0));
                    end else begin
                        check_output("sb_word", 32'(mon_word), 32'(exp_q.pop_front()));
                    end
                    words_seen++;
                end
            end else begin
                check_output("idle_dout_zero", 32'(dout), 32'(0));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit ok;
        int ycnt, yfirst, gap, cyc;
        logic [23:0] stream3;
        logic [15:0] stream4;
        logic [3:0]  seq5;

        vecs[0] = '{word: 8'hB3, bits: 8'b1011_0011, y_cnt: 1, y_first: 4};
        vecs[1] = '{word: 8'h5B, bits: 8'b0101_1011, y_cnt: 2, y_first: 5};
        vecs[2] = '{word: 8'h2D, bits: 8'b0010_1101, y_cnt: 1, y_first: 6};
        vecs[3] = '{word: 8'h00, bits: 8'b0000_0000, y_cnt: 0, y_first: 0};
        vecs[4] = '{word: 8'hFF, bits: 8'b1111_1111, y_cnt: 0, y_first: 0};

        // Reset state
        @(negedge clk);
        check_output("rst_in_ready", 32'(in_ready), 32'(0));
        check_output("rst_dout_valid", 32'(dout_valid), 32'(0));
        check_output("rst_busy", 32'(busy), 32'(0));
        check_output("rst_sow", 32'(sow), 32'(0));
        rst = 1'b0;
        #1;
        check_output("post_rst_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of 8'hFF
        apply_stimulus(8'hFF, ok);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_output("midword_valid", 32'(dout_valid), 32'(1));
        #2 rst = 1'b1;
        #1;
        check_output("async_dout", 32'(dout), 32'(0));
        check_output("async_dout_valid", 32'(dout_valid), 32'(0));
        check_output("async_in_ready", 32'(in_ready), 32'(0));
        check_output("async_busy", 32'(busy), 32'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("release_in_ready", 32'(in_ready), 32'(1));
        ycnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (dout_valid) ycnt++;
        end
        check_output("discarded_word", 32'(ycnt), 32'(0));
        @(posedge clk);
        #1;

        // Single words from the table
        foreach (vecs[v]) begin
            apply_stimulus(vecs[v].word, ok);
            in_valid = 1'b0;
            @(negedge clk);
            check_output("latency_idle", 32'(dout_valid), 32'(0));
            check_output("latency_busy", 32'(busy), 32'(1));
            ycnt = 0;
            yfirst = 0;
            for (int k = 0; k <= 8; k++) begin
                @(negedge clk);
                if (k < 8) begin
                    check_output($sformatf("v%0d_dout%0d", v, k), 32'(dout), 32'(vecs[v].bits[7-k]));
                    check_output($sformatf("v%0d_valid%0d", v, k), 32'(dout_valid), 32'(1));
                    check_output($sformatf("v%0d_sow%0d", v, k), 32'(sow), 32'(k == 0));
                end else begin
                    check_output($sformatf("v%0d_end_valid", v), 32'(dout_valid), 32'(0));
                    check_output($sformatf("v%0d_end_dout", v), 32'(dout), 32'(0));
                end
                if (k > 0 && y) begin
                    ycnt++;
                    if (yfirst == 0) yfirst = k;
                end
            end
            check_output($sformatf("v%0d_y_count", v), 32'(ycnt), 32'(vecs[v].y_cnt));
            check_output($sformatf("v%0d_y_first", v), 32'(yfirst), 32'(vecs[v].y_first));
            @(posedge clk);
            #1;
        end

        // Back-to-back A5, 0B, D2 with in_valid held high
        stream3 = 24'b1010_0101_0000_1011_1101_0010;
        fork
            begin
                apply_stimulus(8'hA5, ok);
                apply_stimulus(8'h0B, ok);
                apply_stimulus(8'hD2, ok);
                in_valid = 1'b0;
            end
            begin
                cyc = 0;
                while (!dout_valid && cyc < 20) begin
                    @(negedge clk);
                    cyc++;
                end
                check_output("b2b_start", 32'(dout_valid), 32'(1));
                for (int c = 0; c < 24; c++) begin
                    if (c > 0) @(negedge clk);
                    check_output($sformatf("b2b_valid%0d", c), 32'(dout_valid), 32'(1));
                    check_output($sformatf("b2b_dout%0d", c), 32'(dout), 32'(stream3[23-c]));
                    check_output($sformatf("b2b_sow%0d", c), 32'(sow), 32'(c % 8 == 0));
                    check_output($sformatf("b2b_ready%0d", c), 32'(in_ready),
                                 32'((c >= 16) || (c % 8 == 7)));
                end
                @(negedge clk);
                check_output("b2b_end", 32'(dout_valid), 32'(0));
            end
        join
        @(posedge clk);
        #1;

        // Next word offered only on the last-bit cycle of 0F
        stream4 = 16'b0000_1111_1111_0000;
        apply_stimulus(8'h0F, ok);
        in_valid = 1'b0;
        cyc = 0;
        while (!dout_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            check_output($sformatf("late_valid%0d", c), 32'(dout_valid), 32'(1));
            check_output($sformatf("late_dout%0d", c), 32'(dout), 32'(stream4[15-c]));
            check_output($sformatf("late_sow%0d", c), 32'(sow), 32'(c % 8 == 0));
            if (c == 7) begin
                check_output("late_ready", 32'(in_ready), 32'(1));
                in_data  = 8'hF0;
                in_valid = 1'b1;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check_output("late_end", 32'(dout_valid), 32'(0));

        // LSB-first, 4-bit instance
        seq5 = 4'b1011;
        @(posedge clk);
        #1;
        in_data4  = 4'b1101;
        in_valid4 = 1'b1;
        @(negedge clk);
        check_output("w4_ready", 32'(in_ready4), 32'(1));
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        @(negedge clk);
        check_output("w4_latency", 32'(dout_valid4), 32'(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output($sformatf("w4_dout%0d", i), 32'(dout4), 32'(seq5[3-i]));
            check_output($sformatf("w4_valid%0d", i), 32'(dout_valid4), 32'(1));
            check_output($sformatf("w4_sow%0d", i), 32'(sow4), 32'(i == 0));
        end
        @(negedge clk);
        check_output("w4_end", 32'(dout_valid4), 32'(0));

        // Random in_valid gaps against a scoreboard
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        for (int w = 0; w < 1000; w++) begin
            gap = $urandom_range(0, 4);
            if (gap > 2) begin
                in_valid = 1'b0;
                repeat (gap - 2) begin
                    @(posedge clk);
                    #1;
                end
            end
            apply_stimulus(8'($urandom), ok);
            if (ok) exp_q.push_back(in_data);
        end
        in_valid = 1'b0;
        cyc = 0;
        while ((busy || dout_valid) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        check_output("sb_word_count", 32'(words_seen), 32'(1000));
        check_output("sb_leftover", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
